// File: rtl/atm_session_ctrl_if.sv
// Session controller bus: card, keypad and amount inputs toward the controller,
// with the registered state, operand and result pulses coming back.
interface atm_session_ctrl_if #(
  parameter int PIN_DIGITS = 4,
  parameter int BAL_W      = 16
);
  logic                    card_in;
  logic [4*PIN_DIGITS-1:0] card_pin;
  logic [BAL_W-1:0]        card_bal;
  logic                    key_valid;
  logic [3:0]              key_digit;
  logic                    key_enter;
  logic                    key_cancel;
  logic                    amt_valid;
  logic [BAL_W-1:0]        amt;

  logic [3:0]              state_code;
  logic [BAL_W-1:0]        balance;
  logic [3:0]              opnd;
  logic [1:0]              lang;
  logic                    txn_ok;
  logic                    txn_err;
  logic                    card_eject;
  logic                    card_retain;
  logic                    bal_show;
  logic                    xfer_out;
  logic [BAL_W-1:0]        xfer_amt;

  modport master (
    output card_in, card_pin, card_bal, key_valid, key_digit, key_enter,
           key_cancel, amt_valid, amt,
    input  state_code, balance, opnd, lang, txn_ok, txn_err, card_eject,
           card_retain, bal_show, xfer_out, xfer_amt
  );

  modport slave (
    input  card_in, card_pin, card_bal, key_valid, key_digit, key_enter,
           key_cancel, amt_valid, amt,
    output state_code, balance, opnd, lang, txn_ok, txn_err, card_eject,
           card_retain, bal_show, xfer_out, xfer_amt
  );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session FSM owning the PIN and balance registers; every output is registered one cycle after its strobe.
// No backpressure: strobes arriving in a state that does not consume them are dropped.
module atm_session_ctrl #(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int BAL_W          = 16
) (
  input logic               clk,
  input logic               rst,
  atm_session_ctrl_if.slave sess
);
  localparam int PIN_W = 4 * PIN_DIGITS;
  localparam int CNT_W = $clog2(PIN_DIGITS + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_BAL     = 4'd1;
  localparam logic [3:0] S_WDRAW   = 4'd2;
  localparam logic [3:0] S_DEP     = 4'd3;
  localparam logic [3:0] S_XFER    = 4'd4;
  localparam logic [3:0] S_EXIT    = 4'd5;
  localparam logic [3:0] S_NEWPASS = 4'd6;
  localparam logic [3:0] S_LANG    = 4'd7;
  localparam logic [3:0] S_SCAN    = 4'd8;
  localparam logic [3:0] S_PASS    = 4'd9;
  localparam logic [3:0] S_OPT     = 4'd10;
  localparam logic [3:0] S_ANY     = 4'd11;

  logic [3:0]       state_q, state_d;
  logic             card_q;
  logic [PIN_W-1:0] pin_q, pin_d;
  logic [PIN_W-1:0] dig_q, dig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic [TO_W-1:0]  inact_q, inact_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [3:0]       opnd_q, opnd_d;
  logic [1:0]       lang_q, lang_d;
  logic [BAL_W-1:0] xfer_amt_q, xfer_amt_d;
  logic             txn_ok_q, txn_ok_d;
  logic             txn_err_q, txn_err_d;
  logic             card_eject_q, card_eject_d;
  logic             card_retain_q, card_retain_d;
  logic             bal_show_q, bal_show_d;
  logic             xfer_out_q, xfer_out_d;

  logic             card_rise, card_fall, key_ok, any_strobe;
  logic             legal, active, timeout, pin_full, amt_fits;
  logic [BAL_W:0]   dep_sum;

  assign card_rise  = sess.card_in & ~card_q;
  assign card_fall  = ~sess.card_in & card_q;
  assign key_ok     = sess.key_valid && (sess.key_digit <= 4'd9);
  assign any_strobe = sess.key_valid | sess.key_enter | sess.key_cancel | sess.amt_valid;
  assign legal      = (state_q <= S_ANY);
  assign active     = legal && (state_q != S_IDLE) && (state_q != S_EXIT);
  assign timeout    = active && (inact_q == TO_W'(TIMEOUT_CYCLES));
  assign pin_full   = (cnt_q == CNT_W'(PIN_DIGITS));
  assign amt_fits   = (sess.amt != '0) && (sess.amt <= balance_q);
  assign dep_sum    = {1'b0, balance_q} + {1'b0, sess.amt};

  always_comb begin
    state_d       = state_q;
    pin_d         = pin_q;
    dig_d         = dig_q;
    cnt_d         = cnt_q;
    try_d         = try_q;
    balance_d     = balance_q;
    opnd_d        = opnd_q;
    lang_d        = lang_q;
    xfer_amt_d    = xfer_amt_q;
    txn_ok_d      = 1'b0;
    txn_err_d     = 1'b0;
    card_retain_d = 1'b0;
    bal_show_d    = 1'b0;
    xfer_out_d    = 1'b0;

    if (!legal) begin
      state_d = S_IDLE;
    end else if (state_q != S_IDLE && card_fall) begin
      state_d = S_IDLE;
    end else if (active && sess.key_cancel) begin
      state_d = S_EXIT;
    end else if (timeout) begin
      state_d = S_EXIT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (card_rise) state_d = S_SCAN;
        end
        S_SCAN: begin
          pin_d     = sess.card_pin;
          balance_d = sess.card_bal;
          try_d     = '0;
          state_d   = S_PASS;
        end
        S_PASS: begin
          if (sess.key_enter) begin
            if (pin_full && dig_q == pin_q) begin
              state_d = S_OPT;
            end else begin
              try_d = try_q + TRY_W'(1);
              dig_d = '0;
              cnt_d = '0;
              if (try_q == TRY_W'(MAX_TRIES - 1)) begin
                card_retain_d = 1'b1;
                state_d       = S_IDLE;
              end
            end
          end else if (key_ok && !pin_full) begin
            dig_d = {dig_q[PIN_W-5:0], sess.key_digit};
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_OPT: begin
          if (key_ok) opnd_d = sess.key_digit;
          if (sess.key_enter) begin
            case (opnd_q)
              4'd1:    state_d = S_BAL;
              4'd2:    state_d = S_WDRAW;
              4'd3:    state_d = S_DEP;
              4'd4:    state_d = S_XFER;
              4'd5:    state_d = S_EXIT;
              4'd6:    state_d = S_NEWPASS;
              4'd7:    state_d = S_LANG;
              default: txn_err_d = 1'b1;
            endcase
          end
        end
        S_BAL: begin
          bal_show_d = 1'b1;
          state_d    = S_ANY;
        end
        S_WDRAW, S_XFER: begin
          if (sess.amt_valid) begin
            if (amt_fits) begin
              balance_d = balance_q - sess.amt;
              txn_ok_d  = 1'b1;
              if (state_q == S_XFER) begin
                xfer_out_d = 1'b1;
                xfer_amt_d = sess.amt;
              end
            end else begin
              txn_err_d = 1'b1;
            end
            state_d = S_ANY;
          end
        end
        S_DEP: begin
          // The saturated value is kept even though the deposit is flagged as an error.
          if (sess.amt_valid) begin
            if (dep_sum[BAL_W]) begin
              balance_d = '1;
              txn_err_d = 1'b1;
            end else begin
              balance_d = dep_sum[BAL_W-1:0];
              txn_ok_d  = 1'b1;
            end
            state_d = S_ANY;
          end
        end
        S_NEWPASS: begin
          if (sess.key_enter) begin
            if (pin_full) begin
              pin_d    = dig_q;
              txn_ok_d = 1'b1;
            end else begin
              txn_err_d = 1'b1;
            end
            state_d = S_ANY;
          end else if (key_ok && !pin_full) begin
            dig_d = {dig_q[PIN_W-5:0], sess.key_digit};
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_LANG: begin
          if (key_ok) opnd_d = sess.key_digit;
          if (sess.key_enter) begin
            if (opnd_q <= 4'd3) begin
              lang_d   = opnd_q[1:0];
              txn_ok_d = 1'b1;
              state_d  = S_ANY;
            end else begin
              txn_err_d = 1'b1;
            end
          end
        end
        S_ANY: begin
          if (key_ok) opnd_d = sess.key_digit;
          if (sess.key_enter) begin
            if (opnd_q == 4'd1)      state_d = S_OPT;
            else if (opnd_q == 4'd0) state_d = S_EXIT;
          end
        end
        S_EXIT: begin
          if (!sess.card_in) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Every state change starts digit collection afresh.
    if (state_d != state_q) begin
      dig_d = '0;
      cnt_d = '0;
    end
    card_eject_d = (state_d == S_EXIT) && (state_q != S_EXIT);
    inact_d      = (any_strobe || state_d != state_q || !active) ? '0 : inact_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      card_q        <= 1'b1;
      pin_q         <= '0;
      dig_q         <= '0;
      cnt_q         <= '0;
      try_q         <= '0;
      inact_q       <= '0;
      balance_q     <= '0;
      opnd_q        <= '0;
      lang_q        <= '0;
      xfer_amt_q    <= '0;
      txn_ok_q      <= 1'b0;
      txn_err_q     <= 1'b0;
      card_eject_q  <= 1'b0;
      card_retain_q <= 1'b0;
      bal_show_q    <= 1'b0;
      xfer_out_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      card_q        <= sess.card_in;
      pin_q         <= pin_d;
      dig_q         <= dig_d;
      cnt_q         <= cnt_d;
      try_q         <= try_d;
      inact_q       <= inact_d;
      balance_q     <= balance_d;
      opnd_q        <= opnd_d;
      lang_q        <= lang_d;
      xfer_amt_q    <= xfer_amt_d;
      txn_ok_q      <= txn_ok_d;
      txn_err_q     <= txn_err_d;
      card_eject_q  <= card_eject_d;
      card_retain_q <= card_retain_d;
      bal_show_q    <= bal_show_d;
      xfer_out_q    <= xfer_out_d;
    end
  end

  assign sess.state_code  = state_q;
  assign sess.balance     = balance_q;
  assign sess.opnd        = opnd_q;
  assign sess.lang        = lang_q;
  assign sess.xfer_amt    = xfer_amt_q;
  assign sess.txn_ok      = txn_ok_q;
  assign sess.txn_err     = txn_err_q;
  assign sess.card_eject  = card_eject_q;
  assign sess.card_retain = card_retain_q;
  assign sess.bal_show    = bal_show_q;
  assign sess.xfer_out    = xfer_out_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed table-driven bench for atm_session_ctrl plus hand sequences for timeout and mid-transaction reset.
module tb_atm_session_ctrl;
  localparam int BW = 16;
  localparam bit [5:0] P_OK = 6'b100000, P_ER = 6'b010000, P_EJ = 6'b001000;
  localparam bit [5:0] P_RT = 6'b000100, P_BS = 6'b000010, P_XO = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atm_session_ctrl_if #(.PIN_DIGITS(4), .BAL_W(BW)) sess ();

  atm_session_ctrl #(
    .PIN_DIGITS(4), .MAX_TRIES(3), .TIMEOUT_CYCLES(255), .BAL_W(BW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sess(sess)
  );

  typedef struct {
    string     nm;
    bit        card;
    bit        kv;
    bit [3:0]  kd;
    bit        ke;
    bit        kc;
    bit        av;
    bit [15:0] amt;
    bit [15:0] cbal;
    bit [3:0]  st;
    bit [15:0] bal;
    bit [5:0]  pl;
    bit [15:0] xa;
    bit [1:0]  lg;
  } vec_t;

  vec_t      tbl[$];
  int        ntest = 0;
  int        nfail = 0;
  bit        g_card;
  bit [15:0] g_cbal;
  bit [15:0] g_xa;
  bit [1:0]  g_lg;

  function automatic void add(string nm, bit kv, bit [3:0] kd, bit ke, bit kc, bit av,
                              bit [15:0] amt, bit [3:0] st, bit [15:0] bal, bit [5:0] pl);
    vec_t v;
    v.nm = nm; v.card = g_card; v.kv = kv; v.kd = kd; v.ke = ke; v.kc = kc;
    v.av = av; v.amt = amt; v.cbal = g_cbal; v.st = st; v.bal = bal; v.pl = pl;
    v.xa = g_xa; v.lg = g_lg;
    tbl.push_back(v);
  endfunction

  function automatic void idl(string nm, bit [3:0] st, bit [15:0] bal, bit [5:0] pl);
    add(nm, 0, 0, 0, 0, 0, 0, st, bal, pl);
  endfunction
  function automatic void key(bit [3:0] d, bit [3:0] st, bit [15:0] bal);
    add("key", 1, d, 0, 0, 0, 0, st, bal, 0);
  endfunction
  function automatic void ent(string nm, bit [3:0] st, bit [15:0] bal, bit [5:0] pl);
    add(nm, 0, 0, 1, 0, 0, 0, st, bal, pl);
  endfunction
  function automatic void amtv(string nm, bit [15:0] a, bit [3:0] st, bit [15:0] bal, bit [5:0] pl);
    add(nm, 0, 0, 0, 0, 1, a, st, bal, pl);
  endfunction
  function automatic void pin4(bit [3:0] a, bit [3:0] b, bit [3:0] c, bit [3:0] d,
                               bit [3:0] st, bit [15:0] bal);
    key(a, st, bal); key(b, st, bal); key(c, st, bal); key(d, st, bal);
  endfunction

  task automatic drive_idle();
    sess.key_valid = 0; sess.key_digit = 0; sess.key_enter = 0;
    sess.key_cancel = 0; sess.amt_valid = 0; sess.amt = 0;
  endtask

  task automatic apply(input vec_t v);
    bit [5:0] pl;
    @(negedge clk);
    sess.card_in = v.card; sess.card_bal = v.cbal;
    sess.key_valid = v.kv; sess.key_digit = v.kd; sess.key_enter = v.ke;
    sess.key_cancel = v.kc; sess.amt_valid = v.av; sess.amt = v.amt;
    @(posedge clk);
    #1;
    pl = {sess.txn_ok, sess.txn_err, sess.card_eject, sess.card_retain, sess.bal_show, sess.xfer_out};
    ntest++;
    if (sess.state_code !== v.st || sess.balance !== v.bal || pl !== v.pl ||
        sess.xfer_amt !== v.xa || sess.lang !== v.lg) begin
      nfail++;
      $display("FAIL %s: got state=%0d bal=%0d pulses=%b xfer_amt=%0d lang=%0d, want state=%0d bal=%0d pulses=%b xfer_amt=%0d lang=%0d",
               v.nm, sess.state_code, sess.balance, pl, sess.xfer_amt, sess.lang,
               v.st, v.bal, v.pl, v.xa, v.lg);
    end
  endtask

  task automatic check(string nm, int got, int want);
    ntest++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  initial begin
    int mark;
    int n;

    // Session A: withdraw, balance check, transfers, exit.
    g_card = 0; g_cbal = 100; g_xa = 0; g_lg = 0;
    idl("card_low", 0, 0, 0);
    g_card = 1;
    idl("scan", 8, 0, 0);
    idl("enter_pass", 9, 100, 0);
    pin4(1, 2, 3, 4, 9, 100);
    ent("pin_ok", 10, 100, 0);
    key(2, 10, 100); ent("go_wd", 2, 100, 0);
    amtv("wd30", 30, 11, 70, P_OK);
    key(1, 11, 70); ent("ae_opt", 10, 70, 0);
    key(2, 10, 70); ent("go_wd2", 2, 70, 0);
    amtv("wd80_over", 80, 11, 70, P_ER);
    key(1, 11, 70); ent("ae_opt2", 10, 70, 0);
    key(1, 10, 70); ent("go_bal", 1, 70, 0);
    idl("bal_show", 11, 70, P_BS);
    key(9, 11, 70); ent("ae_ignore9", 11, 70, 0);
    key(1, 11, 70); ent("ae_opt3", 10, 70, 0);
    key(4, 10, 70); ent("go_xf", 4, 70, 0);
    amtv("xf_zero", 0, 11, 70, P_ER);
    key(1, 11, 70); ent("ae_opt4", 10, 70, 0);
    key(4, 10, 70); ent("go_xf2", 4, 70, 0);
    g_xa = 50; amtv("xf50", 50, 11, 20, P_OK | P_XO);
    key(1, 11, 20); ent("ae_opt5", 10, 20, 0);
    key(4, 10, 20); ent("go_xf3", 4, 20, 0);
    g_xa = 5; amtv("xf5", 5, 11, 15, P_OK | P_XO);
    key(0, 11, 15); ent("ae_exit", 5, 15, P_EJ);
    idl("exit_hold", 5, 15, 0);
    g_card = 0; idl("exit_idle", 0, 15, 0);

    // Session B: deposit saturation, language, PIN change, cancel.
    g_cbal = 65530; g_card = 1;
    idl("scan_b", 8, 15, 0);
    idl("pass_b", 9, 65530, 0);
    pin4(1, 2, 3, 4, 9, 65530);
    ent("pin_ok_b", 10, 65530, 0);
    key(3, 10, 65530); ent("go_dep", 3, 65530, 0);
    amtv("dep_sat", 10, 11, 65535, P_ER);
    key(1, 11, 65535); ent("ae_opt_b", 10, 65535, 0);
    key(7, 10, 65535); ent("go_lang", 7, 65535, 0);
    key(5, 7, 65535); ent("lang_bad", 7, 65535, P_ER);
    key(2, 7, 65535); g_lg = 2; ent("lang_ok", 11, 65535, P_OK);
    key(1, 11, 65535); ent("ae_opt_b2", 10, 65535, 0);
    key(6, 10, 65535); ent("go_newpin", 6, 65535, 0);
    pin4(5, 6, 7, 8, 6, 65535);
    ent("newpin_ok", 11, 65535, P_OK);
    key(1, 11, 65535); ent("ae_opt_b3", 10, 65535, 0);
    key(6, 10, 65535); ent("go_newpin2", 6, 65535, 0);
    key(1, 6, 65535); ent("newpin_short", 11, 65535, P_ER);
    add("cancel", 0, 0, 0, 1, 0, 0, 5, 65535, P_EJ);
    g_card = 0; idl("cancel_idle", 0, 65535, 0);

    // Session C: three wrong PINs retain the card.
    g_cbal = 100; g_card = 1;
    idl("scan_c", 8, 65535, 0);
    idl("pass_c", 9, 100, 0);
    for (int t = 0; t < 3; t++) begin
      pin4(9, 9, 9, 9, 9, 100);
      if (t < 2) ent("pin_wrong", 9, 100, 0);
      else       ent("pin_retain", 0, 100, P_RT);
    end
    idl("retained_no_rescan", 0, 100, 0);
    g_card = 0; idl("card_out_c", 0, 100, 0);

    // Session D: ignored/overlong digits, bad option, card pulled in WITHDRAW.
    g_card = 1;
    idl("scan_d", 8, 100, 0);
    idl("pass_d", 9, 100, 0);
    key(1, 9, 100); key(12, 9, 100); key(2, 9, 100); key(3, 9, 100);
    key(4, 9, 100); key(5, 9, 100);
    ent("pin_overlong", 10, 100, 0);
    key(8, 10, 100); ent("opt_bad", 10, 100, P_ER);
    key(2, 10, 100); ent("go_wd_d", 2, 100, 0);
    g_card = 0; idl("drop_wd", 0, 100, 0);

    // Session E: reach OPTION_SELECT for the timeout sequence.
    g_card = 1;
    idl("scan_e", 8, 100, 0);
    idl("pass_e", 9, 100, 0);
    pin4(1, 2, 3, 4, 9, 100);
    ent("to_option", 10, 100, 0);
    mark = tbl.size();

    // Session F: after the timeout exit, into DEPOSIT for the reset test.
    g_card = 0; idl("exit_idle_f", 0, 100, 0);
    g_card = 1;
    idl("scan_f", 8, 100, 0);
    idl("pass_f", 9, 100, 0);
    pin4(1, 2, 3, 4, 9, 100);
    ent("pin_ok_f", 10, 100, 0);
    key(3, 10, 100); ent("go_dep_f", 3, 100, 0);

    sess.card_in = 1; sess.card_pin = 16'h1234; sess.card_bal = 0;
    drive_idle();
    rst = 0;
    #23;
    check("reset_state", sess.state_code, 0);
    check("reset_outputs",
          int'(sess.balance) + int'(sess.opnd) + int'(sess.lang) + int'(sess.xfer_amt) +
          int'({sess.txn_ok, sess.txn_err, sess.card_eject, sess.card_retain, sess.bal_show, sess.xfer_out}), 0);
    @(negedge clk);
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("no_edge_after_reset", sess.state_code, 0);

    for (int i = 0; i < mark; i++) apply(tbl[i]);

    @(negedge clk);
    drive_idle();
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (sess.state_code == 4'd5) break;
    end
    check("timeout_cycles", n, 256);
    check("timeout_eject", sess.card_eject, 1);
    repeat (300) @(posedge clk);
    #1;
    check("exit_no_timeout", sess.state_code, 5);

    for (int i = mark; i < tbl.size(); i++) apply(tbl[i]);

    @(negedge clk);
    drive_idle();
    sess.amt_valid = 1; sess.amt = 16'd7;
    #2;
    rst = 0;
    #1;
    check("midreset_state", sess.state_code, 0);
    check("midreset_balance", sess.balance, 0);
    check("midreset_lang", sess.lang, 0);
    @(posedge clk);
    #1;
    check("midreset_no_pulse",
          {sess.txn_ok, sess.txn_err, sess.card_eject, sess.card_retain, sess.bal_show, sess.xfer_out}, 0);
    @(negedge clk);
    drive_idle();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_release_idle", sess.state_code, 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Session controller for the ATM datapath. It tracks the customer session through card scan, PIN entry, option selection and transaction execution, and owns the account balance register. It publishes the current state as a 4-bit `state_code` using the team's standard ATM encoding. That code, with the operand outputs, feeds the downstream transaction/status logic directly.

## Interface
- `PIN_DIGITS`, 4 — number of BCD digits in a PIN
- `MAX_TRIES`, 3 — wrong-PIN attempts before the card is retained
- `TIMEOUT_CYCLES`, 255 — inactivity limit in active states
- `BAL_W`, 16 — balance and amount width
- `clk` in 1 — clock
- `rst` in 1 — reset, asynchronous, active-low
- `card_in` in 1 — card present level
- `card_pin` in 4*PIN_DIGITS — PIN read from the card, BCD, most significant digit first
- `card_bal` in BAL_W — balance read from the card
- `key_valid` in 1 — one-cycle strobe; `key_digit` is valid
- `key_digit` in 4 — keypad digit 0–9; values 10–15 are ignored
- `key_enter` in 1 — one-cycle enter strobe
- `key_cancel` in 1 — one-cycle cancel strobe
- `amt_valid` in 1 — one-cycle strobe; `amt` is valid
- `amt` in BAL_W — transaction amount
- `state_code` out 4 — current state, registered
- `balance` out BAL_W — account balance, registered
- `opnd` out 4 — last accepted key digit, registered
- `lang` out 2 — selected language
- `txn_ok`, `txn_err`, `card_eject`, `card_retain`, `bal_show`, `xfer_out` out 1 each — one-cycle pulses
- `xfer_amt` out BAL_W — transfer amount; valid when `xfer_out` is high

## Operation
State encoding:
- IDLE=0, BALANCE_CHECK=1, WITHDRAW=2, DEPOSIT=3, TRANSFER=4, EXIT=5
- NEW_PASS=6, LANG_USED=7, SCAN_CARD=8, ENTER_PASS=9, OPTION_SELECT=10, ANYTHING_ELSE=11
- Codes 12–15 are illegal and recover to IDLE on the next clock.

Transitions:
- IDLE → SCAN_CARD on the rising edge of `card_in`.
- SCAN_CARD (one cycle): latch `card_pin` into the internal PIN register and `card_bal` into `balance`. Clear the digit buffer and the try counter. Go to ENTER_PASS.
- ENTER_PASS: each `key_valid` shifts `key_digit` into the digit buffer.
  - Digits beyond PIN_DIGITS are dropped.
  - On `key_enter` with exactly PIN_DIGITS digits equal to the PIN register → OPTION_SELECT.
  - Any other `key_enter` increments the try counter and clears the buffer.
  - When tries reach MAX_TRIES: pulse `card_retain` and go to IDLE; no eject.
- OPTION_SELECT: the last `key_valid` digit is held in `opnd`. `key_enter` dispatches on it:
  - 1→BALANCE_CHECK, 2→WITHDRAW, 3→DEPOSIT, 4→TRANSFER, 5→EXIT, 6→NEW_PASS, 7→LANG_USED.
  - Any other digit pulses `txn_err` and stays in OPTION_SELECT.
- BALANCE_CHECK: pulse `bal_show` for one cycle → ANYTHING_ELSE.
- WITHDRAW, on `amt_valid`:
  - If `amt` ≤ `balance` and `amt` ≠ 0: `balance` −= `amt`, pulse `txn_ok`.
  - Otherwise pulse `txn_err` and leave `balance` unchanged.
  - Go to ANYTHING_ELSE.
- TRANSFER: same checks as WITHDRAW; on success also pulse `xfer_out` with `xfer_amt`=`amt`.
- DEPOSIT, on `amt_valid`:
  - `balance` += `amt`, saturating at 2^BAL_W−1.
  - Pulse `txn_ok`, or `txn_err` if saturation occurred; the saturated value is still stored.
  - Go to ANYTHING_ELSE.
- NEW_PASS: collect digits as in ENTER_PASS.
  - On `key_enter` with PIN_DIGITS digits: replace the PIN register, pulse `txn_ok`.
  - Otherwise pulse `txn_err`.
  - Either way go to ANYTHING_ELSE.
- LANG_USED: `key_enter` with `opnd` 0–3 sets `lang`=`opnd`, pulses `txn_ok` → ANYTHING_ELSE. Other values pulse `txn_err` and stay.
- ANYTHING_ELSE: `key_enter` with `opnd`=1 → OPTION_SELECT; `opnd`=0 → EXIT; others are ignored.
- EXIT: pulse `card_eject` on entry. Go to IDLE once `card_in` is low.

Global priority, highest first:
1. `card_in` falling in any non-IDLE state → IDLE immediately; no eject.
2. `key_cancel` in any state except IDLE/EXIT → EXIT.
3. Timeout → EXIT.
4. Normal transitions.

- Inactivity counter: cleared on any strobe or state change; counts in all states except IDLE/EXIT; reaching TIMEOUT_CYCLES → EXIT.
- Keys and amounts arriving in states that do not consume them are ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `state_code`=0, `balance`=0, `opnd`=0, `lang`=0, `xfer_amt`=0
  - all pulses 0
  - internal PIN, buffer, try counter and inactivity counter = 0
- Transition latency: a state transition is visible on `state_code` one cycle after the triggering strobe.
- Pulses (`txn_ok`, etc.) assert in the same cycle that `balance` updates and `state_code` changes.
- `amt_valid` and `key_enter` in the same cycle: only the input the current state consumes is acted on.
- Reset asserted mid-transaction clears everything immediately; no pulse is emitted.

## Test plan
- Reset with `card_in`=1 → `state_code`=0; release reset → stays 0 until `card_in` goes 0→1, then 8, then 9.
- Card PIN 1234, keys 1,2,3,4, enter → `state_code`=10. Three entries of 9999 → `card_retain` pulse, `state_code`=0.
- Balance 100: option 2, `amt`=30 → `balance`=70, `txn_ok`. Then option 2, `amt`=80 → `txn_err`, `balance`=70.
- BAL_W=16, balance 65530: deposit `amt`=10 → `balance`=65535, `txn_err`.
- Transfer `amt`=5 from 20 → `xfer_out` with `xfer_amt`=5, `balance`=15. Then anything-else digit 0 → EXIT with `card_eject`; `card_in` low → IDLE.
- In OPTION_SELECT with no keys for 255 cycles → EXIT. `card_in` dropped during WITHDRAW → IDLE next cycle, no eject.
